// File: rtl/fp_divider_seq_if.sv
// Handshake bundle for fp_divider_seq: operand channel (in_valid/in_ready)
// and result channel (out_valid/out_ready) with the W-bit data buses.
interface fp_divider_seq_if #(
  parameter int W = 12
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_input_1;
  logic [W-1:0] data_input_2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] data_output;
  logic         div_by_zero;
  logic         done;

  modport master (
    output in_valid, data_input_1, data_input_2, out_ready,
    input  in_ready, out_valid, data_output, div_by_zero, done
  );

  modport slave (
    input  in_valid, data_input_1, data_input_2, out_ready,
    output in_ready, out_valid, data_output, div_by_zero, done
  );
endinterface

// File: rtl/fp_divider_seq.sv
// fp_divider_seq: sequential floating-point divider, format {sign, exp, man}
// with hidden leading one. Radix-2 restoring, one quotient bit per cycle.
// Zero operands (exp == 0) flush; divide-by-zero, overflow and underflow
// are resolved to NaN / infinity / zero.
// Optional build macro FP_DIV_ROUND_NEAREST_EN: round to nearest, ties to
// even. Without it the mantissa is truncated. Latency is the same either way.
module fp_divider_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 6,
  parameter int BIAS  = 15
) (
  input  logic            clk,
  input  logic            rst,
  fp_divider_seq_if.slave bus
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int Q_W   = MAN_W + 3;
  localparam int CNT_W = $clog2(MAN_W + 4);
  localparam logic [CNT_W-1:0]          CNT_START = CNT_W'(MAN_W + 3);
  localparam logic signed [EXP_W+1:0]   BIAS_E    = (EXP_W + 2)'(BIAS);
  localparam logic signed [EXP_W+1:0]   EXP_MAX_E = (EXP_W + 2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0]   ONE_E     = (EXP_W + 2)'(1);
  localparam logic signed [EXP_W+1:0]   ZERO_E    = (EXP_W + 2)'(0);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t               state_r, state_s;
  logic                 sign_r;
  logic [EXP_W-1:0]     exp1_r, exp2_r;
  logic [MAN_W:0]       div_r;
  logic [MAN_W+1:0]     rem_r;
  logic [Q_W-1:0]       quo_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [W-1:0]         data_output_r;
  logic                 dbz_r, out_valid_r, in_ready_r;

  logic                 sign_in_s, zero1_s, zero2_s, special_s;
  logic [W-1:0]         special_res_s, norm_res_s;
  logic [MAN_W+2:0]     trial_s;
  logic                 q_bit_s;
  logic [MAN_W+1:0]     rem_step_s;
  logic signed [EXP_W+1:0] e_s;
  logic [MAN_W-1:0]     mant_s;
  logic [MAN_W:0]       mant_sum_s;
  logic                 guard_s, sticky_s, round_up_s;

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.done        = out_valid_r;
  assign bus.data_output = data_output_r;
  assign bus.div_by_zero = dbz_r;

  // Classify incoming operands and form the direct special-case result.
  always_comb begin
    sign_in_s = bus.data_input_1[W-1] ^ bus.data_input_2[W-1];
    zero1_s   = (bus.data_input_1[W-2:MAN_W] == {EXP_W{1'b0}});
    zero2_s   = (bus.data_input_2[W-2:MAN_W] == {EXP_W{1'b0}});
    special_s = zero1_s | zero2_s;
    if (zero2_s && zero1_s) begin
      special_res_s = {sign_in_s, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (zero2_s) begin
      special_res_s = {sign_in_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      special_res_s = {sign_in_s, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    end
  end

  // One restoring-division step: subtract divisor, keep or restore, shift.
  always_comb begin
    trial_s = {1'b0, rem_r} - {2'b00, div_r};
    q_bit_s = ~trial_s[MAN_W+2];
    if (q_bit_s) begin
      rem_step_s = trial_s[MAN_W+1:0] << 1;
    end else begin
      rem_step_s = rem_r << 1;
    end
  end

  // Normalise the quotient, round, and clamp the exponent range.
  always_comb begin
    e_s = $signed({2'b00, exp1_r}) - $signed({2'b00, exp2_r}) + BIAS_E;
    if (quo_r[Q_W-1]) begin
      mant_s   = quo_r[MAN_W+1:2];
      guard_s  = quo_r[1];
      sticky_s = quo_r[0] | (rem_r != {(MAN_W+2){1'b0}});
    end else begin
      mant_s   = quo_r[MAN_W:1];
      guard_s  = quo_r[0];
      sticky_s = (rem_r != {(MAN_W+2){1'b0}});
      e_s      = e_s - ONE_E;
    end
`ifdef FP_DIV_ROUND_NEAREST_EN
    round_up_s = guard_s & (sticky_s | mant_s[0]);
`else
    // Truncation: guard and sticky do not influence the result.
    round_up_s = (guard_s | sticky_s) & 1'b0;
`endif
    mant_sum_s = {1'b0, mant_s} + {{MAN_W{1'b0}}, round_up_s};
    if (mant_sum_s[MAN_W]) begin
      e_s = e_s + ONE_E;
    end else begin
      e_s = e_s;
    end
    if (e_s >= EXP_MAX_E) begin
      norm_res_s = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (e_s <= ZERO_E) begin
      norm_res_s = {sign_r, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    end else begin
      norm_res_s = {sign_r, e_s[EXP_W-1:0], mant_sum_s[MAN_W-1:0]};
    end
  end

  // Next-state logic for the IDLE/DIV/NORM/DONE sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_s = special_s ? DONE : DIV;
        end else begin
          state_s = IDLE;
        end
      end
      DIV: begin
        if (cnt_r == CNT_W'(1)) begin
          state_s = NORM;
        end else begin
          state_s = DIV;
        end
      end
      NORM: state_s = DONE;
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register, handshake flags and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      dbz_r         <= 1'b0;
      data_output_r <= {W{1'b0}};
      sign_r        <= 1'b0;
      exp1_r        <= {EXP_W{1'b0}};
      exp2_r        <= {EXP_W{1'b0}};
      div_r         <= {(MAN_W+1){1'b0}};
      rem_r         <= {(MAN_W+2){1'b0}};
      quo_r         <= {Q_W{1'b0}};
      cnt_r         <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            sign_r <= sign_in_s;
            exp1_r <= bus.data_input_1[W-2:MAN_W];
            exp2_r <= bus.data_input_2[W-2:MAN_W];
            div_r  <= {1'b1, bus.data_input_2[MAN_W-1:0]};
            rem_r  <= {1'b0, 1'b1, bus.data_input_1[MAN_W-1:0]};
            quo_r  <= {Q_W{1'b0}};
            cnt_r  <= CNT_START;
            if (special_s) begin
              data_output_r <= special_res_s;
              dbz_r         <= zero2_s;
            end
          end
        end
        DIV: begin
          rem_r <= rem_step_s;
          quo_r <= {quo_r[Q_W-2:0], q_bit_s};
          cnt_r <= cnt_r - CNT_W'(1);
        end
        NORM: begin
          data_output_r <= norm_res_s;
          dbz_r         <= 1'b0;
        end
        DONE: begin
          data_output_r <= data_output_r;
        end
        default: begin
          data_output_r <= data_output_r;
        end
      endcase
    end
  end
endmodule
